// File: rtl/vend_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vend_pkg                                                     |
// | Description : Shared types and constants for the change dispenser: FSM    |
// |               state type, coin_type encodings, default coin values and a  |
// |               coin-value lookup helper.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE  = 2'b00,
        COIN_SMALL = 2'b01,
        COIN_MID   = 2'b10,
        COIN_LARGE = 2'b11
    } coin_t;

    localparam int c_DEF_VAL_LARGE = 10;
    localparam int c_DEF_VAL_MID   = 5;
    localparam int c_DEF_VAL_SMALL = 1;

    // Credit value of a coin encoding for a given set of coin denominations.
    function automatic logic [7:0] coin_value(input coin_t coin,
                                              input int    val_large,
                                              input int    val_mid,
                                              input int    val_small);
        logic [7:0] v;
        v = 8'd0;
        case (coin)
            COIN_LARGE: v = 8'(val_large);
            COIN_MID:   v = 8'(val_mid);
            COIN_SMALL: v = 8'(val_small);
            default:    v = 8'd0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/change_dispenser_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : change_dispenser_if                                          |
// | Description : Request / coin-ejector handshake bundle for the change      |
// |               dispenser. master = requester/ejector side, slave = the     |
// |               dispenser itself.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface change_dispenser_if;
    import vend_pkg::*;

    logic       start;
    logic [7:0] amount;
    logic       large_empty;
    logic       mid_empty;
    logic       coin_ready;
    logic       coin_valid;
    coin_t      coin_type;
    logic       busy;
    logic       done;
    logic [7:0] remaining;

    modport master (
        output start, amount, large_empty, mid_empty, coin_ready,
        input  coin_valid, coin_type, busy, done, remaining
    );

    modport slave (
        input  start, amount, large_empty, mid_empty, coin_ready,
        output coin_valid, coin_type, busy, done, remaining
    );

endinterface
`default_nettype wire

// File: rtl/change_coin_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : change_coin_select                                           |
// | Description : Greedy coin picker: largest available coin whose value does |
// |               not exceed the remaining credit. Small coin is always       |
// |               available and worth 1, so any nonzero amount is payable.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module change_coin_select
    import vend_pkg::*;
#(
    parameter int VAL_LARGE = c_DEF_VAL_LARGE,
    parameter int VAL_MID   = c_DEF_VAL_MID
) (
    input  wire [7:0] remaining,
    input  wire       large_empty,
    input  wire       mid_empty,
    output coin_t     coin_type
);

    // Priority pick from largest to smallest denomination.
    always_comb begin
        coin_type = COIN_NONE;
        if (remaining == 8'd0) begin
            coin_type = COIN_NONE;
        end else if (!large_empty && (remaining >= 8'(VAL_LARGE))) begin
            coin_type = COIN_LARGE;
        end else if (!mid_empty && (remaining >= 8'(VAL_MID))) begin
            coin_type = COIN_MID;
        end else begin
            coin_type = COIN_SMALL;
        end
    end

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : change_dispenser                                             |
// | Description : Pays out a credit amount as a sequence of coins through a   |
// |               valid/ready ejector handshake. FSM IDLE->SELECT->EMIT...    |
// |               ->DONE, every output driven straight from a register.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module change_dispenser
    import vend_pkg::*;
#(
    parameter int VAL_LARGE = c_DEF_VAL_LARGE,
    parameter int VAL_MID   = c_DEF_VAL_MID,
    parameter int VAL_SMALL = c_DEF_VAL_SMALL
) (
    input wire                clk,
    input wire                reset,
    change_dispenser_if.slave bus
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_remaining;
    logic [7:0] w_remaining_nxt;
    logic       r_coin_valid;
    logic       w_coin_valid_nxt;
    coin_t      r_coin_type;
    coin_t      w_coin_type_nxt;
    coin_t      w_sel_coin;
    logic       r_busy;
    logic       r_done;
    logic [7:0] w_coin_val;
    logic [7:0] w_paid_down;

    // Empty flags reach the picker directly but its result is only latched in
    // SELECT, so tube changes during EMIT cannot disturb the offered coin.
    change_coin_select #(
        .VAL_LARGE (VAL_LARGE),
        .VAL_MID   (VAL_MID)
    ) u_select (
        .remaining   (r_remaining),
        .large_empty (bus.large_empty),
        .mid_empty   (bus.mid_empty),
        .coin_type   (w_sel_coin)
    );

    // Credit left after the coin currently offered is taken; clamps at zero
    // so remaining can never wrap even with odd denominations.
    always_comb begin
        w_coin_val  = coin_value(r_coin_type, VAL_LARGE, VAL_MID, VAL_SMALL);
        w_paid_down = (w_coin_val > r_remaining) ? 8'd0 : (r_remaining - w_coin_val);
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_remaining_nxt  = r_remaining;
        w_coin_valid_nxt = 1'b0;
        w_coin_type_nxt  = COIN_NONE;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt     = ST_SELECT;
                    w_remaining_nxt = bus.amount;
                end
            end
            ST_SELECT: begin
                if (r_remaining == 8'd0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt      = ST_EMIT;
                    w_coin_valid_nxt = 1'b1;
                    w_coin_type_nxt  = w_sel_coin;
                end
            end
            ST_EMIT: begin
                if (r_coin_valid && bus.coin_ready) begin
                    w_state_nxt     = ST_SELECT;
                    w_remaining_nxt = w_paid_down;
                end else begin
                    w_coin_valid_nxt = 1'b1;
                    w_coin_type_nxt  = r_coin_type;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; busy/done follow the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_remaining  <= 8'd0;
            r_coin_valid <= 1'b0;
            r_coin_type  <= COIN_NONE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_remaining  <= w_remaining_nxt;
            r_coin_valid <= w_coin_valid_nxt;
            r_coin_type  <= w_coin_type_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_done       <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.coin_valid = r_coin_valid;
    assign bus.coin_type  = r_coin_type;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.remaining  = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_change_dispenser                                          |
// | Description : Table-driven payout vectors with a coin scoreboard, plus    |
// |               hand-written reset and busy-start sequences.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_change_dispenser;

    typedef struct {
        logic [7:0]  amount;
        logic        large_empty;
        logic        mid_empty;
        int          stall;     // ready-low cycles per coin
        logic        flip;      // toggle large_empty while stalled
        logic [15:0] coins;     // expected coins, first coin in bits [1:0]
        int          ncoins;
    } vec_t;

    typedef struct {
        logic [1:0] coin;
        logic [7:0] rem;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[8];

    change_dispenser_if bus ();

    change_dispenser dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] val_of(input logic [1:0] c);
        case (c)
            2'b11:   return 8'd10;
            2'b10:   return 8'd5;
            2'b01:   return 8'd1;
            default: return 8'd0;
        endcase
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int         gap;
        int         stall_left;
        int         cyc;
        logic       finished;
        logic       fresh;
        logic [7:0] rem;
        exp_t       e;
        rem = v.amount;
        for (int k = 0; k < v.ncoins; k++) begin
            e.coin = v.coins[2*k +: 2];
            e.rem  = rem;
            sb.push_back(e);
            rem = rem - val_of(e.coin);
        end
        @(negedge clk);
        bus.amount      = v.amount;
        bus.large_empty = v.large_empty;
        bus.mid_empty   = v.mid_empty;
        bus.coin_ready  = 1'b1;
        bus.start       = 1'b1;
        gap = 0; stall_left = v.stall; cyc = 0; finished = 1'b0; fresh = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        gap++;
        check($sformatf("v%0d_sel_busy", idx), 32'(bus.busy), 32'd1);
        check($sformatf("v%0d_sel_rem", idx), 32'(bus.remaining), 32'(v.amount));
        check($sformatf("v%0d_sel_valid", idx), 32'(bus.coin_valid), 32'd0);
        while (!finished && cyc < 100) begin
            @(negedge clk);
            cyc++;
            gap++;
            if (bus.done) begin
                check($sformatf("v%0d_done_lat", idx), 32'(gap), 32'd2);
                check($sformatf("v%0d_done_rem", idx), 32'(bus.remaining), 32'd0);
                check($sformatf("v%0d_done_busy", idx), 32'(bus.busy), 32'd1);
                check($sformatf("v%0d_coins_left", idx), 32'(sb.size()), 32'd0);
                finished = 1'b1;
            end else if (bus.coin_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL v%0d_extra_coin actual=%0d required=none", idx, bus.coin_type);
                    finished = 1'b1;
                end else begin
                    e = sb[0];
                    if (fresh) begin
                        check($sformatf("v%0d_coin_lat", idx), 32'(gap), 32'd2);
                        fresh = 1'b0;
                    end
                    check($sformatf("v%0d_coin_type", idx), 32'(bus.coin_type), 32'(e.coin));
                    check($sformatf("v%0d_coin_rem", idx), 32'(bus.remaining), 32'(e.rem));
                    if (stall_left > 0) begin
                        bus.coin_ready = 1'b0;
                        stall_left--;
                        if (v.flip) bus.large_empty = ~v.large_empty;
                    end else begin
                        bus.coin_ready = 1'b1;
                        e = sb.pop_front();
                        gap = 0;
                        fresh = 1'b1;
                        stall_left = v.stall;
                    end
                end
            end
        end
        if (!finished) begin
            checks++; errors++;
            $display("FAIL v%0d_timeout actual=%0d cycles required=done", idx, cyc);
        end
        sb.delete();
        @(negedge clk);
        check($sformatf("v%0d_post_done", idx), 32'(bus.done), 32'd0);
        check($sformatf("v%0d_post_busy", idx), 32'(bus.busy), 32'd0);
        check($sformatf("v%0d_post_valid", idx), 32'(bus.coin_valid), 32'd0);
    endtask

    initial begin
        int nemit;
        int cyc;
        vecs[0] = '{8'd17, 1'b0, 1'b0, 0, 1'b0, 16'h005B, 4};
        vecs[1] = '{8'd0,  1'b0, 1'b0, 0, 1'b0, 16'h0000, 0};
        vecs[2] = '{8'd23, 1'b1, 1'b0, 0, 1'b0, 16'h15AA, 7};
        vecs[3] = '{8'd10, 1'b0, 1'b0, 3, 1'b1, 16'h0003, 1};
        vecs[4] = '{8'd7,  1'b1, 1'b1, 0, 1'b0, 16'h1555, 7};
        vecs[5] = '{8'd14, 1'b0, 1'b1, 0, 1'b0, 16'h0157, 5};
        vecs[6] = '{8'd5,  1'b0, 1'b0, 0, 1'b0, 16'h0002, 1};
        vecs[7] = '{8'd16, 1'b0, 1'b0, 2, 1'b0, 16'h001B, 3};

        bus.start = 1'b0; bus.amount = 8'd0; bus.large_empty = 1'b0;
        bus.mid_empty = 1'b0; bus.coin_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.coin_valid), 32'd0);
        check("rst_type", 32'(bus.coin_type), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rem", 32'(bus.remaining), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // 255 payout: ignored start while busy, then reset during the 5th EMIT.
        @(negedge clk);
        bus.amount = 8'd255; bus.large_empty = 1'b0; bus.mid_empty = 1'b0;
        bus.coin_ready = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.amount = 8'd0;
        check("r255_sel_busy", 32'(bus.busy), 32'd1);
        check("r255_sel_rem", 32'(bus.remaining), 32'd255);
        @(negedge clk);
        bus.start = 1'b0;
        check("r255_ign_valid", 32'(bus.coin_valid), 32'd1);
        check("r255_ign_type", 32'(bus.coin_type), 32'd3);
        check("r255_ign_rem", 32'(bus.remaining), 32'd255);
        nemit = 1;
        cyc = 0;
        while (nemit < 5 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (bus.coin_valid) nemit++;
        end
        if (nemit < 5) begin
            checks++; errors++;
            $display("FAIL r255_timeout actual=%0d emits required=5", nemit);
        end
        check("r255_emit5_rem", 32'(bus.remaining), 32'd215);
        check("r255_emit5_type", 32'(bus.coin_type), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        check("r255_rst_valid", 32'(bus.coin_valid), 32'd0);
        check("r255_rst_type", 32'(bus.coin_type), 32'd0);
        check("r255_rst_busy", 32'(bus.busy), 32'd0);
        check("r255_rst_done", 32'(bus.done), 32'd0);
        check("r255_rst_rem", 32'(bus.remaining), 32'd0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("r255_idle_busy", 32'(bus.busy), 32'd0);
            check("r255_idle_valid", 32'(bus.coin_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter VAL_LARGE, default 10, value of large coin in credit units.
REQ-002 Parameter VAL_MID, default 5, value of mid coin in credit units.
REQ-003 Parameter VAL_SMALL, default 1, value of small coin; SHALL be 1 so any amount is payable.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request to dispense amount; sampled only in IDLE.
REQ-007 amount  in  8  credit to return, read from the credit register output.
REQ-008 large_empty  in  1  large-coin tube empty; large coins not selectable.
REQ-009 mid_empty  in  1  mid-coin tube empty; mid coins not selectable.
REQ-010 coin_ready  in  1  ejector accepts the offered coin this cycle.
REQ-011 coin_valid  out  1  coin offered to ejector.
REQ-012 coin_type  out  2  00 none, 01 small, 10 mid, 11 large.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when remaining reaches 0.
REQ-015 remaining  out  8  credit still to be paid.

Function
REQ-016 The block SHALL implement FSM states IDLE, SELECT, EMIT, DONE, all outputs registered.
REQ-017 IDLE: start=1 at an edge SHALL load remaining<=amount and move to SELECT.
REQ-018 SELECT: remaining==0 -> DONE; else pick the largest coin with value<=remaining and tube not empty (small always available), latch coin_type, move to EMIT.
REQ-019 EMIT: coin_valid=1 with coin_type held stable until coin_ready=1.
REQ-020 EMIT handshake edge (coin_valid&coin_ready): remaining<=remaining-value(coin_type), coin_valid<=0, coin_type<=00, state<=SELECT.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; busy=0 in the IDLE cycle following.
REQ-022 Latency: first coin_valid SHALL be high 2 cycles after the start edge; each next coin 2 cycles after the previous handshake.
REQ-023 start while busy SHALL be ignored; amount is not resampled.
REQ-024 amount=0: start -> SELECT -> DONE, no coin offered.
REQ-025 large_empty/mid_empty SHALL be evaluated only in SELECT; a change during EMIT does not alter the offered coin.
REQ-026 Subtraction SHALL never underflow; remaining is unsigned 8-bit, max 255.

Reset
REQ-027 On reset=1 at an edge: state=IDLE, remaining=0, coin_valid=0, coin_type=00, busy=0, done=0, regardless of current state.
REQ-028 Reset mid-EMIT SHALL drop coin_valid at that edge; the partial payout is not resumed.

Structure
REQ-029 Shared package vend_pkg SHALL hold the FSM state type, coin_type encodings, and default coin values.
REQ-030 Greedy selection SHALL be a combinational sub-module change_coin_select (remaining, empty flags -> coin_type).

Verification
REQ-031 amount=17, no empties, coin_ready=1 -> coins 11,10,01,01; done one cycle after the last SELECT; remaining=0.
REQ-032 amount=0 -> no coin_valid; done pulses 2 cycles after the start edge; busy high for exactly 2 cycles.
REQ-033 amount=23, large_empty=1 -> coins 10,10,10,10,01,01,01; then done.
REQ-034 amount=10, coin_ready low 3 cycles -> coin_valid=1, coin_type=11, remaining=10 held stable; then handshake, remaining=0, done.
REQ-035 amount=255, reset asserted during the 5th EMIT -> next cycle all outputs zero, state IDLE; a second start with amount 0 while busy is ignored.
